// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the instruction memory loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-serial loader filling the instruction memory.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    imem_loader_if.slave      s,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign s.in_ready = (state_q != DONE) && (state_q != ERROR);
    assign xfer       = s.in_valid && s.in_ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (xfer && state_q != CSUM)
            csum_d = csum_q ^ s.in_data;
`endif
        if (xfer) begin
            unique case (state_q)
                LEN_HI: begin
                    len_d   = {s.in_data, 8'h00};
                    state_d = LEN_LO;
                end
                LEN_LO: begin
                    len_d = {len_q[15:8], s.in_data};
                    if (len_d > DEPTH_W)
                        state_d = ERROR;
                    else if (len_d == 16'd0)
                        state_d = FIN;
                    else
                        state_d = DATA_HI;
                end
                DATA_HI: begin
                    hi_d    = s.in_data;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = {hi_q, s.in_data};
                    cnt_d   = cnt_q + 16'd1;
                    state_d = (cnt_d == len_q) ? FIN : DATA_HI;
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    state_d = (s.in_data == csum_q) ? DONE : ERROR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LEN_HI;
            len_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // DONE becomes visible only once the final write strobe has retired,
    // so the CPU never fetches a word in the cycle it is written.
    assign done       = (state_q == DONE) && !we_q;
    assign cpu_hold   = !done;
    assign error      = (state_q == ERROR);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time,
// popped when imem_we is observed.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_we;
  logic [8:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(512), .ADDR_W(9)) dut (
    .clock      (clock),
    .reset      (reset),
    .s          (bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_count = 0;
  int last_we = 0;
  int prev_we = 0;
  logic [7:0] run_x = 8'h00;
  logic [24:0] exp_q[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!reset && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_we got addr=%0h data=%h expected none",
                 imem_addr, imem_wdata);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0h data=%h expected addr=%0h data=%h",
                   imem_addr, imem_wdata, e[24:16], e[15:0]);
        end
      end
      prev_we = last_we;
      last_we = cyc;
      we_count++;
    end
  end

  // Called at a negedge; the byte transfers at the next posedge.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      bus.in_valid = 1'b0;
      @(negedge clock);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got in_ready=0 expected 1");
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    run_x = run_x ^ b;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run_x = 8'h00;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if ({bus.in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error}
        !== {1'b1, 1'b0, 9'd0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s got rdy=%b we=%b a=%0h d=%h hold=%b done=%b err=%b expected 1 0 0 0000 1 0 0",
               nm, bus.in_ready, imem_we, imem_addr, imem_wdata, cpu_hold,
               done, error);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clock);
    do_reset();
    check_reset_vals("reset_state");
  endtask

  task automatic test_back_to_back();
    int wc;
    do_reset();
    wc = we_count;
    exp_q.push_back({9'd0, 16'h410F});
    exp_q.push_back({9'd1, 16'h4207});
    send(8'h00); send(8'h02); send(8'h41);
    send(8'h0F); send(8'h42); send(8'h07);
    chk("b2b_we_pulse", {31'd0, imem_we}, 32'd1);
    chk("b2b_done_during_we", {31'd0, done}, 32'd0);
    chk("b2b_ready_during_we", {31'd0, bus.in_ready}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    send(run_x);
    idle(0);
`else
    idle(1);
`endif
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_hold", {31'd0, cpu_hold}, 32'd0);
    chk("b2b_ready_after", {31'd0, bus.in_ready}, 32'd0);
    idle(3);
    chk("b2b_spacing", last_we - prev_we, 32'd2);
    chk("b2b_we_count", we_count - wc, 32'd2);
    chk("b2b_done_sticky", {31'd0, done}, 32'd1);
  endtask

  task automatic test_zero_len();
    int wc;
    do_reset();
    wc = we_count;
    send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    idle(0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_hold", {31'd0, cpu_hold}, 32'd0);
    idle(4);
    chk("zero_no_we", we_count - wc, 32'd0);
  endtask

  task automatic test_oversize();
    int wc;
    do_reset();
    wc = we_count;
    send(8'h02); send(8'h01);
    idle(0);
    chk("over_error", {31'd0, error}, 32'd1);
    chk("over_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("over_hold", {31'd0, cpu_hold}, 32'd1);
    chk("over_done", {31'd0, done}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (4) @(negedge clock);
    idle(1);
    chk("over_no_we", we_count - wc, 32'd0);
    chk("over_err_sticky", {31'd0, error}, 32'd1);
  endtask

  task automatic test_max_len();
    do_reset();
    send(8'h02); send(8'h00);
    idle(0);
    chk("max_len_accept", {31'd0, bus.in_ready}, 32'd1);
    chk("max_len_no_err", {31'd0, error}, 32'd0);
  endtask

  task automatic test_gapped();
    int wc;
    do_reset();
    wc = we_count;
    exp_q.push_back({9'd0, 16'hA53C});
    send(8'h00); idle(3);
    send(8'h01); idle(3);
    send(8'hA5); idle(3);
    send(8'h3C); idle(3);
`ifdef LOADER_CHECKSUM_EN
    send(run_x); idle(1);
`endif
    chk("gap_we_count", we_count - wc, 32'd1);
    chk("gap_done", {31'd0, done}, 32'd1);
  endtask

  task automatic test_reset_midload();
    int wc;
    do_reset();
    wc = we_count;
    send(8'h00); send(8'h03); send(8'h12);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h34;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    run_x = 8'h00;
    check_reset_vals("midload_reset");
    send(8'h00); send(8'h01); send(8'hAA);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hBB;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    run_x = 8'h00;
    chk("midload_we_cancel", {31'd0, imem_we}, 32'd0);
    check_reset_vals("midload_reset2");
    chk("midload_no_we", we_count - wc, 32'd0);
    exp_q.push_back({9'd0, 16'hBEEF});
    send(8'h00); send(8'h01); send(8'hBE); send(8'hEF);
`ifdef LOADER_CHECKSUM_EN
    send(run_x);
`endif
    idle(2);
    chk("midload_done", {31'd0, done}, 32'd1);
    chk("midload_we_count", we_count - wc, 32'd1);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    exp_q.push_back({9'd0, 16'h410F});
    send(8'h00); send(8'h01); send(8'h41); send(8'h0F); send(8'h4F);
    idle(1);
    chk("csum_ok_done", {31'd0, done}, 32'd1);
    chk("csum_ok_err", {31'd0, error}, 32'd0);
    do_reset();
    exp_q.push_back({9'd0, 16'h410F});
    send(8'h00); send(8'h01); send(8'h41); send(8'h0F); send(8'h4E);
    idle(1);
    chk("csum_bad_err", {31'd0, error}, 32'd1);
    chk("csum_bad_hold", {31'd0, cpu_hold}, 32'd1);
    chk("csum_bad_done", {31'd0, done}, 32'd0);
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_zero_len();
    test_oversize();
    test_max_len();
    test_gapped();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader that fills the 16-bit CPU's 512-word instruction memory before execution. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It issues one write per word into the instruction memory and holds the CPU until the image is complete. It is the write side of the instruction memory the CPU fetches from at word index PC>>1.

## Interface
- DEPTH, 512, instruction memory depth in words; maximum accepted word count.
- ADDR_W, 9, word-address width; must satisfy 2^ADDR_W >= DEPTH.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  ADDR_W  word index being written.
- imem_wdata  out  16  instruction word being written.
- cpu_hold  out  1  while high, the CPU must not advance its PC.
- done  out  1  image fully loaded and accepted; sticky.
- error  out  1  stream rejected; sticky.

## Operation
- A byte transfers on a rising edge where in_valid and in_ready are both high. When in_ready is low, in_data is ignored.
- Stream format:
  - Length high byte, then length low byte, giving a 16-bit word count N.
  - Then 2N data bytes, sent as high byte then low byte for each word.
  - Then an optional checksum byte (see Configuration).
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERROR.
  - LEN_HI -> LEN_LO on transfer.
  - LEN_LO, on transfer:
    - -> ERROR if N > DEPTH.
    - -> DONE (or CSUM) if N = 0.
    - Otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO on transfer.
  - DATA_LO, on transfer: writes the word and increments the word counter.
    - -> DATA_HI if words written < N.
    - Otherwise -> DONE (or CSUM).
  - CSUM, on transfer: -> DONE if the received byte matches, else -> ERROR.
  - DONE and ERROR are terminal until reset.
- in_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM; 0 in DONE and ERROR.
- Word k (0-based) goes to imem_addr = k. imem_wdata = {high byte, low byte}. Addresses never wrap, because N <= DEPTH is enforced.
- The high byte is held in a register between DATA_HI and DATA_LO. Idle cycles between bytes (in_valid low) are allowed anywhere, of any length.
- cpu_hold = 1 in every state except DONE. error = 1 only in ERROR. done = 1 only in DONE.
- Words already written before an ERROR are not erased. cpu_hold stays high in ERROR.

## Timing
- Reset values:
  - State LEN_HI.
  - in_ready = 1 on the first cycle after reset.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - cpu_hold = 1, done = 0, error = 0.
  - Word counter = 0, checksum accumulator = 0.
- imem_we is registered. It is high for exactly one cycle, the cycle after the edge that transferred a word's low byte. imem_addr and imem_wdata are valid in that same cycle.
- Back-to-back bytes are sustained at one byte per cycle, giving one word write every two cycles.
- Transition to DONE occurs on the edge after the final imem_we cycle, or after the CSUM or zero-length transfer. done rises and cpu_hold falls together. The CPU therefore never fetches a word in the cycle it is written.
- Reset asserted mid-load takes effect on the next edge regardless of state or handshake. It returns the block to LEN_HI with counters cleared. A pending imem_we is cancelled, so imem_we = 0 in the following cycle.
- If reset and a transfer coincide, reset wins and the byte is dropped.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the data (or after the length, if N = 0), the loader enters CSUM and expects one byte.
  - That byte must equal the XOR of every preceding stream byte, length bytes included.
  - Match -> DONE. Mismatch -> ERROR.
- LOADER_CHECKSUM_EN undefined:
  - The CSUM state and the accumulator are not built.
  - The loader goes straight to DONE; no trailing byte is consumed.

## Test plan
- Two-word image, back-to-back bytes 00 02 41 0F 42 07 -> two writes:
  - imem_we pulses with addr 0 / wdata 410F.
  - Two cycles later, addr 1 / wdata 4207.
  - done = 1 and cpu_hold = 0 one cycle after the second pulse; in_ready = 0 thereafter.
- Zero length 00 00 -> no imem_we ever; done = 1 one cycle after the second byte (checksum disabled).
- Oversize length 02 01 (513) -> error = 1 and in_ready = 0 on the cycle after the second byte; cpu_hold stays 1; no writes.
- Gapped stream 00 01 A5 3C with in_valid low for 3 cycles between each byte -> a single write of addr 0 / wdata A53C; no spurious imem_we during the gaps.
- Reset mid-load after 00 03 12 -> all outputs return to reset values; the following stream 00 01 BE EF writes addr 0 / wdata BEEF, then done.
- LOADER_CHECKSUM_EN:
  - 00 01 41 0F 4F -> done.
  - 00 01 41 0F 4E -> addr 0 is written with 410F, then error = 1 and cpu_hold stays 1.
